// File: rtl/wb_arb_pkg.sv
// Shared definitions for the result-bus writeback arbiter: channel ids, FSM states,
// default tenure cap and the circular channel increment.
package wb_arb_pkg;

    localparam int NUM_CH_DEF    = 3;
    localparam int SEL_W_DEF     = 2;
    localparam int CNT_W_DEF     = 3;
    localparam int MAX_BEATS_DEF = 4;

    localparam logic [1:0] CH_ALU = 2'd0;
    localparam logic [1:0] CH_MEM = 2'd1;
    localparam logic [1:0] CH_BUS = 2'd2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [1:0] ch_next(input logic [1:0] ch);
        return (ch == CH_BUS) ? CH_ALU : ch + 2'd1;
    endfunction

endpackage

// File: rtl/writeback_arbiter_picker.sv
// Combinational round-robin pick: first set request scanning circularly from ptr.
// Zero latency; no flow control of its own.
module rr_picker_3ch
    import wb_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic       found,
    output logic [1:0] idx
);

    logic [1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = 0; k < 3; k++) begin
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
            cand = ch_next(cand);
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter for the 3-channel result mux with capped tenure length.
// Grant visible 1 cycle after request; dst_ready=0 stalls the tenure indefinitely.
module writeback_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int SEL_W     = SEL_W_DEF,
    parameter int MAX_BEATS = MAX_BEATS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] last,
    input  logic              dst_ready,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  sel,
    output logic              xfer_valid,
    output logic [CNT_W-1:0]  beat_cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

    state_e            state_q;
    logic [NUM_CH-1:0] gnt_q;
    logic [SEL_W-1:0]  sel_q;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic [1:0]        rr_ptr_q;

    logic [1:0] pick_ptr;
    logic       pick_found;
    logic [1:0] pick_idx;
    logic       beat;
    logic       tenure_end;

    assign beat = (|(gnt_q & req)) & dst_ready;

    // A withdrawn owner ends its tenure even without a beat; last only counts with a beat.
    assign tenure_end = (beat && (last[sel_q] || beat_cnt_q == CNT_LAST)) || !req[sel_q];

    // While granted, the owner's successor leads the scan so the owner ranks last.
    assign pick_ptr = (state_q == GRANT) ? ch_next(sel_q) : rr_ptr_q;

    rr_picker_3ch u_picker (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            beat_cnt_q <= '0;
            rr_ptr_q   <= CH_ALU;
        end else begin
            case (state_q)
                IDLE: begin
                    beat_cnt_q <= '0;
                    if (pick_found) begin
                        state_q <= GRANT;
                        gnt_q   <= NUM_CH'(1) << pick_idx;
                        sel_q   <= pick_idx;
                    end
                end
                GRANT: begin
                    if (tenure_end) begin
                        rr_ptr_q   <= pick_ptr;
                        beat_cnt_q <= '0;
                        if (pick_found) begin
                            gnt_q <= NUM_CH'(1) << pick_idx;
                            sel_q <= pick_idx;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                        end
                    end else if (beat) begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign sel        = sel_q;
    assign xfer_valid = beat;
    assign beat_cnt   = beat_cnt_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomised and directed bench comparing the arbiter against a transaction-level model
// that tracks owner, priority pointer and beats taken.
module tb_writeback_arbiter;

    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [2:0] last;
    logic       dst_ready;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       xfer_valid;
    logic [2:0] beat_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    int m_owner;
    int m_sel;
    int m_cnt;
    int m_ptr;
    int grant_log[$];

    always #5 clk = ~clk;

    writeback_arbiter #(.MAX_BEATS(MAXB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .last       (last),
        .dst_ready  (dst_ready),
        .gnt        (gnt),
        .sel        (sel),
        .xfer_valid (xfer_valid),
        .beat_cnt   (beat_cnt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int pick(input logic [2:0] r, input int from);
        for (int k = 0; k < 3; k++)
            if (r[(from + k) % 3]) return (from + k) % 3;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_sel   = 0;
        m_cnt   = 0;
        m_ptr   = 0;
    endtask

    // One cycle: drive inputs after the falling edge, compare, then advance the model.
    task automatic step(input logic r, input logic [2:0] rq, input logic [2:0] ls, input logic rd);
        int  p;
        bit  bt;
        bit  done;
        @(negedge clk);
        rst = r; req = rq; last = ls; dst_ready = rd;
        #1;
        bt = (m_owner >= 0) && rq[m_owner] && rd;
        chk("gnt", int'(gnt), (m_owner < 0) ? 0 : (1 << m_owner));
        chk("sel", int'(sel), m_sel);
        chk("beat_cnt", int'(beat_cnt), m_cnt);
        chk("xfer_valid", int'(xfer_valid), int'(bt));
        if (!r) begin
            model_reset();
        end else if (m_owner < 0) begin
            p = pick(rq, m_ptr);
            if (p >= 0) begin
                m_owner = p; m_sel = p; m_cnt = 0;
                grant_log.push_back(p);
            end
        end else begin
            done = (bt && (ls[m_owner] || m_cnt == MAXB - 1)) || !rq[m_owner];
            if (done) begin
                m_ptr = (m_owner + 1) % 3;
                m_cnt = 0;
                p = pick(rq, m_ptr);
                if (p >= 0) begin
                    m_owner = p; m_sel = p;
                    grant_log.push_back(p);
                end else begin
                    m_owner = -1;
                end
            end else if (bt) begin
                m_cnt++;
            end
        end
    endtask

    initial begin
        int seq_ok;
        rst = 1'b0; req = '0; last = '0; dst_ready = 1'b0;
        model_reset();
        @(posedge clk);

        // single request on ch1
        step(1, 3'b010, 3'b010, 1);
        step(1, 3'b010, 3'b010, 1);
        step(1, 3'b000, 3'b010, 1);
        step(1, 3'b000, 3'b000, 1);

        // fairness: expect ch0,ch1,ch2,ch0,... with no idle gap
        step(0, 3'b000, 3'b000, 1);
        grant_log.delete();
        for (int i = 0; i < 9; i++) step(1, 3'b111, 3'b111, 1);
        seq_ok = (grant_log.size() >= 6) ? 1 : 0;
        for (int i = 0; i < grant_log.size() && i < 6; i++)
            if (grant_log[i] != i % 3) seq_ok = 0;
        chk("rr_order", seq_ok, 1);

        // forced end after MAXB beats
        step(0, 3'b000, 3'b000, 1);
        for (int i = 0; i < 8; i++) step(1, 3'b011, 3'b000, 1);

        // stall on ch2
        step(0, 3'b000, 3'b000, 1);
        step(1, 3'b100, 3'b000, 1);
        step(1, 3'b100, 3'b000, 1);
        for (int i = 0; i < 5; i++) step(1, 3'b100, 3'b000, 0);
        for (int i = 0; i < 4; i++) step(1, 3'b100, 3'b000, 1);

        // withdrawal on ch1 after 2 beats, then with another requester waiting
        step(0, 3'b000, 3'b000, 1);
        for (int i = 0; i < 3; i++) step(1, 3'b010, 3'b000, 1);
        step(1, 3'b000, 3'b000, 1);
        step(1, 3'b000, 3'b000, 1);
        for (int i = 0; i < 3; i++) step(1, 3'b010, 3'b000, 1);
        step(1, 3'b101, 3'b000, 1);
        step(1, 3'b101, 3'b000, 1);

        // reset mid-burst
        step(0, 3'b000, 3'b000, 1);
        for (int i = 0; i < 3; i++) step(1, 3'b001, 3'b000, 1);
        step(0, 3'b001, 3'b000, 1);
        step(1, 3'b001, 3'b000, 1);
        step(1, 3'b001, 3'b000, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic       r_rst;
            logic [2:0] r_req;
            logic [2:0] r_last;
            logic       r_rdy;
            r_rst  = ($urandom_range(0, 99) != 0);
            r_req  = 3'($urandom);
            if ($urandom_range(0, 3) != 0) r_req = r_req | 3'b001 << $urandom_range(0, 2);
            r_last = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
            r_rdy  = ($urandom_range(0, 3) != 0);
            step(r_rst, r_req, r_last, r_rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
